// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared encodings and constants for the DMA channel blocks
package dma_pkg;

  // One-hot 4-bit encoding, same style as the read/write masters
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_DONE  = 4'b1000
  } dma_state_e;

  localparam int         DEFAULT_CHUNK_BYTES = 1024;
  localparam logic [2:0] AXI_SIZE_4B         = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR      = 2'b01;

endpackage

// File: rtl/dma_done_capture.sv
// rtl/dma_done_capture.sv - rising-edge detector on a master done level with a sticky seen flag
module dma_done_capture (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic arm,
  input  logic done,
  output logic seen
);

  logic done_q;
  logic seen_q;
  logic rise;

  // done_q tracks the level every cycle, so a done still high from the
  // previous chunk never looks like a fresh edge once armed
  assign rise = arm & done & ~done_q;
  assign seen = seen_q | rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      done_q <= done;
      if (clr) begin
        seen_q <= 1'b0;
      end else begin
        seen_q <= seen;
      end
    end
  end

endmodule

// File: rtl/dma_chunk_sequencer.sv
// rtl/dma_chunk_sequencer.sv - splits one DMA transfer into bounded chunks and sequences both masters
module dma_chunk_sequencer
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 32,
  parameter int CHUNK_BYTES = DEFAULT_CHUNK_BYTES,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src_addr,
  input  logic [ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [LEN_WIDTH-1:0]  i_total_len,
  input  logic                  i_irq_clr,
  output logic                  o_rd_start,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_wr_start,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [LEN_WIDTH-1:0]  o_chunk_len,
  input  logic                  i_rd_done,
  input  logic                  i_wr_done,
  input  logic                  i_rd_err,
  input  logic                  i_wr_err,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_irq,
  output logic [CNT_WIDTH-1:0]  o_chunk_cnt
);

  localparam logic [LEN_WIDTH-1:0] CHUNK_L = LEN_WIDTH'(CHUNK_BYTES);

  dma_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q, chunk_len_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  busy_q, err_q, irq_q;

  logic [LEN_WIDTH-1:0]  len_w, rem_after, rem_src, chunk_nxt;
  logic [ADDR_WIDTH-1:0] chunk_addr;
  logic                  rd_seen, wr_seen, both_seen, err_now;
  logic                  in_issue, in_wait;
  logic                  unused_len_bits;

  assign unused_len_bits = ^i_total_len[1:0];

  assign in_issue = (state == ST_ISSUE);
  assign in_wait  = (state == ST_WAIT);

  dma_done_capture u_rd_cap (
    .clk   (clk),
    .reset (reset),
    .clr   (in_issue),
    .arm   (in_wait),
    .done  (i_rd_done),
    .seen  (rd_seen)
  );

  dma_done_capture u_wr_cap (
    .clk   (clk),
    .reset (reset),
    .clr   (in_issue),
    .arm   (in_wait),
    .done  (i_wr_done),
    .seen  (wr_seen)
  );

  assign len_w      = {i_total_len[LEN_WIDTH-1:2], 2'b00};
  assign rem_after  = remaining_q - chunk_len_q;
  assign both_seen  = rd_seen & wr_seen;
  assign err_now    = err_q | i_rd_err | i_wr_err;
  assign chunk_addr = ADDR_WIDTH'(chunk_len_q);

  // Chunk length is registered on the way into ISSUE, so it is computed
  // from whatever "remaining" will be once that transition happens
  assign rem_src   = (state == ST_IDLE) ? len_w : rem_after;
  assign chunk_nxt = (rem_src > CHUNK_L) ? CHUNK_L : rem_src;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_start) state_nxt = (len_w == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (both_seen) state_nxt = (err_now || rem_after == '0) ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      remaining_q <= '0;
      chunk_len_q <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      // A set in DONE below overrides a clear requested in the same cycle
      if (i_irq_clr) irq_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            rd_addr_q   <= i_src_addr;
            wr_addr_q   <= i_dst_addr;
            remaining_q <= len_w;
            chunk_len_q <= chunk_nxt;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (i_rd_err || i_wr_err) err_q <= 1'b1;
          if (both_seen) begin
            rd_addr_q   <= rd_addr_q + chunk_addr;
            wr_addr_q   <= wr_addr_q + chunk_addr;
            remaining_q <= rem_after;
            chunk_len_q <= chunk_nxt;
            cnt_q       <= cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          irq_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_rd_start  = in_issue;
  assign o_wr_start  = in_issue;
  assign o_rd_addr   = rd_addr_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_chunk_len = chunk_len_q;
  assign o_busy      = busy_q;
  assign o_done      = (state == ST_DONE);
  assign o_err       = err_q;
  assign o_irq       = irq_q;
  assign o_chunk_cnt = cnt_q;

endmodule
